dot_product_mac: RTL and testbench

Sequential, handshaked signed dot-product engine for the NPU datapath. It is the multi-cycle successor to the combinational `DotProduct` unit. It accepts two N-element signed vectors and multiplies LANES element pairs per cycle into a full-precision accumulator. It returns both the full-precision result and an OUT_WIDTH result, which is either truncated (legacy behaviour) or saturated. It sits between the operand buffers and the activation stage.

---
 rtl/dot_product_mac.sv | 173 +++++++++++++++++
 tb/tb_dot_product_mac.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
`default_nettype none
// ============================================================================
//  Module   : dot_product_mac
//  Brief    : Sequential, handshaked signed dot-product engine. Captures two
//             N-element signed vectors, multiplies LANES element pairs per
//             beat into an exact accumulator over N/LANES beats, then presents
//             the full-precision sum together with a truncated or saturated
//             OUT_WIDTH result and an out-of-range flag.
//  Revision : 1.0 - initial release
// ============================================================================
module dot_product_mac #(
    parameter int WIDTH     = 8,
    parameter int N         = 16,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(N),
    parameter int OUT_WIDTH = WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     a [N],
    input  logic signed [WIDTH-1:0]     b [N],
    input  logic                        sat_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        overflow
);

    // N must be a multiple of LANES; one beat consumes LANES element pairs.
    localparam int C_BEATS = N / LANES;
    localparam int C_KW    = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam logic [C_KW-1:0] C_K_LAST = C_KW'(C_BEATS - 1);

    // Signed bounds of the narrowed result, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operand copies; rotated by LANES each beat so the active pairs always
    // sit in elements 0..LANES-1 and no variable index is needed.
    logic signed [WIDTH-1:0]     r_a     [N];
    logic signed [WIDTH-1:0]     r_b     [N];
    logic signed [WIDTH-1:0]     w_a_rot [N];
    logic signed [WIDTH-1:0]     w_b_rot [N];

    logic                        r_sat;
    logic [C_KW-1:0]             r_k;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic signed [2*WIDTH-1:0]   w_prod     [LANES];
    logic signed [ACC_WIDTH-1:0] w_prod_ext [LANES];
    logic signed [ACC_WIDTH-1:0] w_lane_sum;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic signed [OUT_WIDTH-1:0] w_narrow;
    logic                        w_ovf;
    logic                        w_accept;
    logic                        w_out_accept;
    logic                        w_last_beat;

    // Handshake: a pending result may be retired and replaced in one cycle.
    assign out_valid    = (r_state == ST_DONE);
    assign in_ready     = rst_n && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_DONE) && out_ready));
    assign w_accept     = in_valid && in_ready;
    assign w_out_accept = out_valid && out_ready;
    assign w_last_beat  = (r_k == C_K_LAST);

    // Exact per-lane products, sign-extended to the accumulator width.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_prod[gi] =
            $signed({{WIDTH{r_a[gi][WIDTH-1]}}, r_a[gi]}) *
            $signed({{WIDTH{r_b[gi][WIDTH-1]}}, r_b[gi]});
        assign w_prod_ext[gi] = ACC_WIDTH'(w_prod[gi]);
    end

    // Bring the next beat's element pairs down to the lane positions.
    for (genvar gi = 0; gi < N; gi++) begin : g_rotate
        assign w_a_rot[gi] = r_a[(gi + LANES) % N];
        assign w_b_rot[gi] = r_b[(gi + LANES) % N];
    end

    // Sum of all lane products for the current beat.
    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + w_prod_ext[i];
        end
    end

    assign w_acc_next = r_acc + w_lane_sum;
    assign w_ovf      = (w_acc_next > C_OUT_MAX) || (w_acc_next < C_OUT_MIN);

    // Narrowing: keep the low bits, or clamp toward the violated bound.
    always_comb begin
        w_narrow = w_acc_next[OUT_WIDTH-1:0];
        if (r_sat && w_ovf) begin
            w_narrow = w_acc_next[ACC_WIDTH-1] ? C_OUT_MIN[OUT_WIDTH-1:0]
                                               : C_OUT_MAX[OUT_WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE may jump straight back to BUSY on a new accept.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_BUSY;
            ST_BUSY: if (w_last_beat) w_state_next = ST_DONE;
            ST_DONE: if (w_out_accept) begin
                w_state_next = w_accept ? ST_BUSY : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept, rotation while beats are processed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end else if (r_state == ST_BUSY) begin
            r_a <= w_a_rot;
            r_b <= w_b_rot;
        end
    end

    // Accumulation, beat counting and result registers held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat    <= 1'b0;
            r_k      <= '0;
            r_acc    <= '0;
            out      <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            r_sat <= sat_en;
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc <= w_acc_next;
            r_k   <= w_last_beat ? '0 : r_k + 1'b1;
            if (w_last_beat) begin
                out      <= w_narrow;
                acc_out  <= w_acc_next;
                overflow <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot_product_mac
//  Brief    : Self-checking bench for dot_product_mac. Three instances share
//             one clock and reset: N=4/LANES=2, N=4/LANES=4 (single beat,
//             same inputs as the first) and N=16/LANES=4. Results are
//             compared with a plain-arithmetic dot-product reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_mac;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small (N=4) and single-beat instances share these inputs.
    logic               s_in_valid = 1'b0;
    logic               s_sat      = 1'b0;
    logic               s_out_ready = 1'b0;
    logic signed [7:0]  s_a [4];
    logic signed [7:0]  s_b [4];
    logic               s_in_ready, s_out_valid, s_ovf;
    logic signed [7:0]  s_out;
    logic signed [17:0] s_acc;
    logic               d_in_ready, d_out_valid, d_ovf;
    logic signed [7:0]  d_out;
    logic signed [17:0] d_acc;

    // Large (N=16) instance.
    logic               l_in_valid = 1'b0;
    logic               l_sat      = 1'b0;
    logic               l_out_ready = 1'b0;
    logic signed [7:0]  l_a [16];
    logic signed [7:0]  l_b [16];
    logic               l_in_ready, l_out_valid, l_ovf;
    logic signed [7:0]  l_out;
    logic signed [19:0] l_acc;

    dot_product_mac #(.WIDTH(8), .N(4), .LANES(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .sat_en(s_sat), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out(s_out), .acc_out(s_acc), .overflow(s_ovf)
    );

    dot_product_mac #(.WIDTH(8), .N(4), .LANES(4)) u_deg (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(d_in_ready),
        .a(s_a), .b(s_b), .sat_en(s_sat), .out_valid(d_out_valid),
        .out_ready(s_out_ready), .out(d_out), .acc_out(d_acc), .overflow(d_ovf)
    );

    dot_product_mac #(.WIDTH(8), .N(16), .LANES(4)) u_large (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .a(l_a), .b(l_b), .sat_en(l_sat), .out_valid(l_out_valid),
        .out_ready(l_out_ready), .out(l_out), .acc_out(l_acc), .overflow(l_ovf)
    );

    // Reference model state, captured at input accept.
    longint      ma [16];
    longint      mb [16];
    bit          msat;
    longint      exp_acc;
    logic [7:0]  exp_out;
    logic        exp_ovf;

    function automatic longint ref_dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += ma[i] * mb[i];
        return s;
    endfunction

    task automatic set_expect(input int n);
        logic [63:0] bits;
        exp_acc = ref_dot(n);
        exp_ovf = (exp_acc > 127) || (exp_acc < -128);
        bits    = exp_acc;
        if (msat && exp_ovf) exp_out = (exp_acc > 0) ? 8'h7F : 8'h80;
        else                 exp_out = bits[7:0];
    endtask

    function automatic logic [7:0] rnd_elem();
        case (3'($urandom_range(0, 7)))
            3'd0:    return 8'h80;
            3'd1:    return 8'h7F;
            3'd2:    return 8'hFF;
            3'd3:    return 8'h01;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic fill_small();
        for (int i = 0; i < 4; i++) begin s_a[i] = rnd_elem(); s_b[i] = rnd_elem(); end
    endtask

    task automatic fill_large();
        for (int i = 0; i < 16; i++) begin l_a[i] = rnd_elem(); l_b[i] = rnd_elem(); end
    endtask

    // Present the current vectors for one cycle; optionally retire a pending
    // result on the same edge. Inputs are scrambled right after the accept.
    task automatic issue(input bit big, input bit sat, input bit with_oready);
        @(negedge clk);
        msat = sat;
        if (big) begin
            l_in_valid = 1'b1; l_sat = sat;
            if (with_oready) l_out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin ma[i] = l_a[i]; mb[i] = l_b[i]; end
            set_expect(16);
            #1;
            checks++;
            if (l_in_ready !== 1'b1) begin
                errors++; $display("FAIL large_in_ready_at_issue got %b want 1", l_in_ready);
            end
        end else begin
            s_in_valid = 1'b1; s_sat = sat;
            if (with_oready) s_out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin ma[i] = s_a[i]; mb[i] = s_b[i]; end
            set_expect(4);
            #1;
            checks++;
            if (s_in_ready !== 1'b1 || d_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL small_in_ready_at_issue got %b/%b want 1/1", s_in_ready, d_in_ready);
            end
        end
        @(posedge clk);
        #1;
        if (big) begin
            l_in_valid = 1'b0; l_out_ready = 1'b0; l_sat = ~sat;
            fill_large();
        end else begin
            s_in_valid = 1'b0; s_out_ready = 1'b0; s_sat = ~sat;
            fill_small();
        end
    endtask

    // Count edges from accept to out_valid, then check the presented result.
    task automatic wait_result(input bit big, input string nm);
        int cyc  = 0;
        int dcyc = 0;
        bit got  = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!big && dcyc == 0 && d_out_valid === 1'b1) dcyc = cyc;
            got = big ? (l_out_valid === 1'b1) : (s_out_valid === 1'b1);
        end
        checks++;
        if (!got || cyc != (big ? 4 : 2)) begin
            errors++; $display("FAIL %s latency got %0d want %0d", nm, cyc, big ? 4 : 2);
        end
        if (big) begin
            checks++;
            if (l_acc !== 20'(exp_acc)) begin
                errors++; $display("FAIL %s acc_out got %0d want %0d", nm, l_acc, exp_acc);
            end
            checks++;
            if (l_out !== exp_out) begin
                errors++; $display("FAIL %s out got %h want %h", nm, l_out, exp_out);
            end
            checks++;
            if (l_ovf !== exp_ovf) begin
                errors++; $display("FAIL %s overflow got %b want %b", nm, l_ovf, exp_ovf);
            end
        end else begin
            checks++;
            if (s_acc !== 18'(exp_acc)) begin
                errors++; $display("FAIL %s acc_out got %0d want %0d", nm, s_acc, exp_acc);
            end
            checks++;
            if (s_out !== exp_out) begin
                errors++; $display("FAIL %s out got %h want %h", nm, s_out, exp_out);
            end
            checks++;
            if (s_ovf !== exp_ovf) begin
                errors++; $display("FAIL %s overflow got %b want %b", nm, s_ovf, exp_ovf);
            end
            checks++;
            if (dcyc != 1) begin
                errors++; $display("FAIL %s single_beat_latency got %0d want 1", nm, dcyc);
            end
            checks++;
            if (d_acc !== 18'(exp_acc) || d_out !== exp_out || d_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL %s single_beat_result got %0d/%h/%b want %0d/%h/%b",
                         nm, d_acc, d_out, d_ovf, exp_acc, exp_out, exp_ovf);
            end
        end
    endtask

    task automatic consume(input bit big);
        @(negedge clk);
        if (big) l_out_ready = 1'b1; else s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (big) l_out_ready = 1'b0; else s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_out_valid, s_in_ready, l_out_valid, l_in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake got %b%b%b%b want 0000",
                     s_out_valid, s_in_ready, l_out_valid, l_in_ready);
        end
        checks++;
        if (s_out !== '0 || s_acc !== '0 || s_ovf !== 1'b0 ||
            l_out !== '0 || l_acc !== '0 || l_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d/%h/%0d want 0", s_out, s_acc, l_out, l_acc);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_in_ready !== 1'b1 || d_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %b%b%b want 111",
                     s_in_ready, d_in_ready, l_in_ready);
        end
    endtask

    task automatic test_basic();
        s_a = '{8'sd3, 8'sd1, 8'sd1, 8'sd2};
        s_b = '{8'sd3, 8'sd1, 8'sd2, 8'sd1};
        issue(1'b0, 1'b0, 1'b0);
        wait_result(1'b0, "basic");
        checks++;
        if (s_acc !== 18'sd14 || s_out !== 8'h0E || s_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_direct got %0d/%h/%b want 14/0e/0", s_acc, s_out, s_ovf);
        end
        consume(1'b0);
    endtask

    task automatic test_neg_trunc();
        for (int i = 0; i < 4; i++) begin s_a[i] = 8'hFF; s_b[i] = 8'hFF; end
        issue(1'b0, 1'b0, 1'b0);
        wait_result(1'b0, "neg_trunc");
        checks++;
        if (s_acc !== 18'sd4 || s_out !== 8'h04) begin
            errors++; $display("FAIL neg_trunc_direct got %0d/%h want 4/04", s_acc, s_out);
        end
        consume(1'b0);
    endtask

    task automatic test_saturation();
        logic signed [17:0] want_acc;
        logic [7:0]         want_out;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) begin
                s_a[i] = 8'h80;
                s_b[i] = (c == 2) ? 8'h7F : 8'h80;
            end
            issue(1'b0, (c != 0), 1'b0);
            wait_result(1'b0, "saturation");
            want_acc = (c == 2) ? -18'sd65024 : 18'sd65536;
            want_out = (c == 0) ? 8'h00 : ((c == 1) ? 8'h7F : 8'h80);
            checks++;
            if (s_acc !== want_acc || s_out !== want_out || s_ovf !== 1'b1) begin
                errors++;
                $display("FAIL saturation_case%0d got %0d/%h/%b want %0d/%h/1",
                         c, s_acc, s_out, s_ovf, want_acc, want_out);
            end
            consume(1'b0);
        end
    endtask

    task automatic test_back_to_back();
        fill_small();
        issue(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        wait_result(1'b0, "backpressure_first");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out !== exp_out ||
                s_acc !== 18'(exp_acc) || s_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d got v%b r%b %h/%0d/%b want v1 r0 %h/%0d/%b",
                         c, s_out_valid, s_in_ready, s_out, s_acc, s_ovf, exp_out, exp_acc, exp_ovf);
            end
        end
        fill_small();
        issue(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        wait_result(1'b0, "back_to_back_second");
        consume(1'b0);
    endtask

    task automatic test_reset_busy();
        fill_large();
        issue(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (l_out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_busy_no_result cycle %0d got %b want 0", c, l_out_valid);
            end
        end
        for (int i = 0; i < 16; i++) begin l_a[i] = 8'sd1; l_b[i] = 8'sd1; end
        issue(1'b1, 1'b0, 1'b0);
        wait_result(1'b1, "after_busy_reset");
        checks++;
        if (l_out !== 8'd16 || l_acc !== 20'sd16) begin
            errors++; $display("FAIL after_busy_reset_direct got %h/%0d want 10/16", l_out, l_acc);
        end
        consume(1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            fill_small();
            issue(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            wait_result(1'b0, "random_small");
            consume(1'b0);
        end
        for (int it = 0; it < 6; it++) begin
            fill_large();
            issue(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            wait_result(1'b1, "random_large");
            fill_large();
            issue(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            wait_result(1'b1, "random_large_b2b");
            consume(1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin s_a[i] = '0; s_b[i] = '0; end
        for (int i = 0; i < 16; i++) begin l_a[i] = '0; l_b[i] = '0; end
        test_reset();
        test_basic();
        test_neg_trunc();
        test_saturation();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
